mem_port_arbiter: RTL and testbench

Arbiter that shares the single 256×16 memory port between the pipeline's instruction-fetch stage and its load/store stage. Data accesses have priority; a starvation counter guarantees fetch progress. The memory side may take any number of cycles to respond; a timeout detects a hung memory. The block sits between the processor core and the memory model.

---
 rtl/mem_port_arbiter.sv | 203 ++++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between instruction fetch and
// load/store. Load/store wins arbitration, a starvation counter forces a fetch
// grant after STARVE_MAX consecutive load/store grants, and a wait counter
// aborts accesses the memory never completes.
//
// Ports
//   clk, rst                 clock, asynchronous active-low reset
//   if_req/if_addr           fetch request (level) and address
//   if_ack/if_data           fetch completion pulse and fetched word
//   ls_rd_req/ls_wr_req      load / store requests (level)
//   ls_addr/ls_wdata         load/store address and store data
//   ls_ack/ls_rdata          load/store completion pulse and loaded word
//   mem_addr/mem_wdata       registered memory address and store data
//   mem_rd/mem_wr            read / write strobes, held until mem_ready
//   mem_rdata/mem_ready      memory read data and completion
//   mem_err                  sticky timeout flag
module mem_port_arbiter #(
    parameter int unsigned ADDR_W     = 8,
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned STARVE_MAX = 3,
    parameter int unsigned TIMEOUT    = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ack,
    output logic [DATA_W-1:0] if_data,
    input  logic              ls_rd_req,
    input  logic              ls_wr_req,
    input  logic [ADDR_W-1:0] ls_addr,
    input  logic [DATA_W-1:0] ls_wdata,
    output logic              ls_ack,
    output logic [DATA_W-1:0] ls_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_rd,
    output logic              mem_wr,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic              mem_err
);

    localparam int unsigned SC_RAW = $clog2(STARVE_MAX + 1);
    localparam int unsigned SC_W   = (SC_RAW < 2) ? 2 : SC_RAW;
    localparam int unsigned WC_RAW = $clog2(TIMEOUT + 1);
    localparam int unsigned WC_W   = (WC_RAW < 1) ? 1 : WC_RAW;

    localparam logic [SC_W-1:0] STARVE_LIM = SC_W'(STARVE_MAX);
    // Wait counter holds (access cycle - 1); this value marks the last allowed cycle.
    localparam logic [WC_W-1:0] WAIT_LAST  = WC_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_LOAD  = 3'd2,
        S_STORE = 3'd3,
        S_DONE  = 3'd4
    } state_e;

    state_e            state_q, state_d;
    logic [SC_W-1:0]   starve_q, starve_d;
    logic [WC_W-1:0]   wait_q, wait_d;
    logic              if_ack_q, if_ack_d;
    logic              ls_ack_q, ls_ack_d;
    logic [DATA_W-1:0] if_data_q, if_data_d;
    logic [DATA_W-1:0] ls_rdata_q, ls_rdata_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              mem_rd_q, mem_rd_d;
    logic              mem_wr_q, mem_wr_d;
    logic              mem_err_q, mem_err_d;
    logic              access_c;

    assign access_c = (state_q == S_FETCH) || (state_q == S_LOAD) || (state_q == S_STORE);

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: arbitration in IDLE, completion or timeout in access states
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (if_req && (starve_q >= STARVE_LIM)) begin
                    state_d = S_FETCH;
                end else if (ls_wr_req) begin
                    state_d = S_STORE;
                end else if (ls_rd_req) begin
                    state_d = S_LOAD;
                end else if (if_req) begin
                    state_d = S_FETCH;
                end
            end
            S_FETCH, S_LOAD, S_STORE: begin
                if (mem_ready || (wait_q == WAIT_LAST)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output/datapath next values; strobes follow the next state so they are glitch-free flops
    always_comb begin
        starve_d    = starve_q;
        wait_d      = '0;
        if_ack_d    = 1'b0;
        ls_ack_d    = 1'b0;
        if_data_d   = if_data_q;
        ls_rdata_d  = ls_rdata_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_err_d   = mem_err_q;
        mem_rd_d    = (state_d == S_FETCH) || (state_d == S_LOAD);
        mem_wr_d    = (state_d == S_STORE);

        if (state_q == S_IDLE) begin
            if (state_d == S_FETCH) begin
                mem_addr_d = if_addr;
                starve_d   = '0;
            end else if (state_d != S_IDLE) begin
                mem_addr_d = ls_addr;
                if (state_d == S_STORE) begin
                    mem_wdata_d = ls_wdata;
                end
                if (if_req && (starve_q < STARVE_LIM)) begin
                    starve_d = starve_q + SC_W'(1);
                end
            end
            if (!if_req) begin
                starve_d = '0;
            end
        end

        if (access_c) begin
            wait_d = wait_q + WC_W'(1);
            if (state_d == S_DONE) begin
                wait_d = '0;
                // A timed-out access returns zero data and raises the sticky error.
                if (!mem_ready) begin
                    mem_err_d = 1'b1;
                end
                if (state_q == S_FETCH) begin
                    if_ack_d  = 1'b1;
                    if_data_d = mem_ready ? mem_rdata : '0;
                end else begin
                    ls_ack_d = 1'b1;
                    if (state_q == S_LOAD) begin
                        ls_rdata_d = mem_ready ? mem_rdata : '0;
                    end
                end
            end
        end
    end

    // Datapath and output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            starve_q    <= '0;
            wait_q      <= '0;
            if_ack_q    <= 1'b0;
            ls_ack_q    <= 1'b0;
            if_data_q   <= '0;
            ls_rdata_q  <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_rd_q    <= 1'b0;
            mem_wr_q    <= 1'b0;
            mem_err_q   <= 1'b0;
        end else begin
            starve_q    <= starve_d;
            wait_q      <= wait_d;
            if_ack_q    <= if_ack_d;
            ls_ack_q    <= ls_ack_d;
            if_data_q   <= if_data_d;
            ls_rdata_q  <= ls_rdata_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_rd_q    <= mem_rd_d;
            mem_wr_q    <= mem_wr_d;
            mem_err_q   <= mem_err_d;
        end
    end

    assign if_ack    = if_ack_q;
    assign ls_ack    = ls_ack_q;
    assign if_data   = if_data_q;
    assign ls_rdata  = ls_rdata_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_rd    = mem_rd_q;
    assign mem_wr    = mem_wr_q;
    assign mem_err   = mem_err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed testbench for mem_port_arbiter with a small memory responder.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [7:0]  if_addr;
    logic        if_ack;
    logic [15:0] if_data;
    logic        ls_rd_req;
    logic        ls_wr_req;
    logic [7:0]  ls_addr;
    logic [15:0] ls_wdata;
    logic        ls_ack;
    logic [15:0] ls_rdata;
    logic [7:0]  mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_rd;
    logic        mem_wr;
    logic [15:0] mem_rdata;
    logic        mem_ready;
    logic        mem_err;

    int total = 0;
    int bad   = 0;

    // Responder controls and observation counters
    int   wait_n = 1;
    logic tie_hi = 1'b0;
    logic stuck  = 1'b0;
    int   scnt = 0;
    int   rd_n = 0;
    int   wr_n = 0;
    int   both_n = 0;
    int   ls_ack_n = 0;
    int   if_ack_n = 0;
    logic [15:0] tmem [256];

    mem_port_arbiter #(
        .ADDR_W(8), .DATA_W(16), .STARVE_MAX(3), .TIMEOUT(15)
    ) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_data(if_data),
        .ls_rd_req(ls_rd_req), .ls_wr_req(ls_wr_req), .ls_addr(ls_addr),
        .ls_wdata(ls_wdata), .ls_ack(ls_ack), .ls_rdata(ls_rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rd(mem_rd), .mem_wr(mem_wr),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready), .mem_err(mem_err)
    );

    always #5 clk = ~clk;

    // Memory model: raises mem_ready on the wait_n-th strobe cycle
    initial begin
        logic rdy;
        mem_ready = 1'b0;
        mem_rdata = 16'hBEEF;
        forever begin
            @(posedge clk);
            #1;
            if (ls_ack) ls_ack_n++;
            if (if_ack) if_ack_n++;
            if (mem_rd && mem_wr) both_n++;
            if (mem_rd) rd_n++;
            if (mem_wr) wr_n++;
            if (mem_rd || mem_wr) begin
                scnt++;
                rdy = tie_hi || (!stuck && (scnt >= wait_n));
            end else begin
                scnt = 0;
                rdy  = tie_hi;
            end
            if (rdy && mem_wr) tmem[mem_addr] = mem_wdata;
            mem_rdata = rdy ? tmem[mem_addr] : 16'hBEEF;
            mem_ready = rdy;
        end
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        cyc();
        cyc();
        total++;
        if ({if_ack, ls_ack, mem_rd, mem_wr, mem_err} !== 5'b0) begin
            $display("FAIL reset_flags got=%b exp=00000", {if_ack, ls_ack, mem_rd, mem_wr, mem_err});
            bad++;
        end
        total++;
        if ({if_data, ls_rdata, mem_addr, mem_wdata} !== 56'h0) begin
            $display("FAIL reset_data got=%h exp=0", {if_data, ls_rdata, mem_addr, mem_wdata});
            bad++;
        end
        rst = 1'b1;
        cyc();
    endtask

    task automatic test_zero_wait_fetch();
        tie_hi = 1'b1;
        rd_n = 0;
        if_addr = 8'd1;
        if_req = 1'b1;
        cyc();
        total++;
        if ({mem_rd, mem_wr, if_ack, mem_addr} !== {3'b100, 8'd1}) begin
            $display("FAIL zw_cycle1 got=%b/%h exp=100/01", {mem_rd, mem_wr, if_ack}, mem_addr);
            bad++;
        end
        cyc();
        total++;
        if ({if_ack, mem_rd, if_data} !== {2'b10, 16'hE801}) begin
            $display("FAIL zw_ack got=%b/%h exp=10/e801", {if_ack, mem_rd}, if_data);
            bad++;
        end
        if_req = 1'b0;
        cyc();
        total++;
        if (if_ack !== 1'b0 || rd_n != 1) begin
            $display("FAIL zw_after got=ack%b rd_cycles=%0d exp=ack0 rd_cycles=1", if_ack, rd_n);
            bad++;
        end
        tie_hi = 1'b0;
        cyc();
    endtask

    task automatic test_store_load();
        int n;
        wait_n = 3;
        wr_n = 0;
        ls_addr = 8'd130;
        ls_wdata = 16'h0003;
        ls_wr_req = 1'b1;
        n = 0;
        do begin cyc(); n++; end while (!ls_ack && n < 40);
        total++;
        if (n != 4) begin
            $display("FAIL store_latency got=%0d exp=4", n);
            bad++;
        end
        ls_wr_req = 1'b0;
        cyc();
        total++;
        if (wr_n != 3 || tmem[130] !== 16'h0003) begin
            $display("FAIL store_strobe got=wr_cycles%0d mem=%h exp=wr_cycles3 mem=0003", wr_n, tmem[130]);
            bad++;
        end
        ls_rd_req = 1'b1;
        n = 0;
        do begin cyc(); n++; end while (!ls_ack && n < 40);
        total++;
        if (n != 4 || ls_rdata !== 16'h0003) begin
            $display("FAIL load_130 got=lat%0d data=%h exp=lat4 data=0003", n, ls_rdata);
            bad++;
        end
        ls_rd_req = 1'b0;
        cyc();
    endtask

    task automatic test_contention();
        int n;
        logic [7:0] seq;
        wait_n = 1;
        seq = '0;
        cyc();
        if_ack_n = 0;
        if_addr = 8'd1;
        ls_addr = 8'd130;
        if_req = 1'b1;
        ls_rd_req = 1'b1;
        for (int t = 0; t < 8; t++) begin
            n = 0;
            do begin cyc(); n++; end while (!(if_ack || ls_ack) && n < 20);
            seq[t] = if_ack;
        end
        total++;
        if (seq !== 8'b1000_1000) begin
            $display("FAIL contention_seq got=%b exp=10001000 (bit0 first, 1=fetch)", seq);
            bad++;
        end
        if_req = 1'b0;
        ls_rd_req = 1'b0;
        cyc();
        cyc();
        total++;
        if (if_ack_n != 2) begin
            $display("FAIL contention_fetches got=%0d exp=2", if_ack_n);
            bad++;
        end
    endtask

    task automatic test_simul_rd_wr();
        int n;
        wait_n = 2;
        rd_n = 0;
        wr_n = 0;
        ls_ack_n = 0;
        ls_addr = 8'd129;
        ls_wdata = 16'h00FF;
        ls_rd_req = 1'b1;
        ls_wr_req = 1'b1;
        n = 0;
        do begin cyc(); n++; end while (!ls_ack && n < 40);
        total++;
        if (n != 3) begin
            $display("FAIL simul_latency got=%0d exp=3", n);
            bad++;
        end
        ls_rd_req = 1'b0;
        ls_wr_req = 1'b0;
        cyc();
        cyc();
        cyc();
        total++;
        if (wr_n != 2 || rd_n != 0 || ls_ack_n != 1 || tmem[129] !== 16'h00FF) begin
            $display("FAIL simul_rd_wr got=wr%0d rd%0d acks%0d mem=%h exp=wr2 rd0 acks1 mem=00ff",
                     wr_n, rd_n, ls_ack_n, tmem[129]);
            bad++;
        end
    endtask

    task automatic test_timeout();
        int n;
        logic err_pre;
        total++;
        if (mem_err !== 1'b0) begin
            $display("FAIL err_before_timeout got=%b exp=0", mem_err);
            bad++;
        end
        stuck = 1'b1;
        err_pre = 1'b0;
        ls_addr = 8'd5;
        ls_rd_req = 1'b1;
        n = 0;
        do begin
            cyc();
            n++;
            if (!ls_ack) err_pre = err_pre | mem_err;
        end while (!ls_ack && n < 40);
        total++;
        if (n != 16 || ls_rdata !== 16'h0000) begin
            $display("FAIL timeout_ack got=lat%0d data=%h exp=lat16 data=0000", n, ls_rdata);
            bad++;
        end
        total++;
        if (mem_err !== 1'b1 || err_pre !== 1'b0) begin
            $display("FAIL timeout_err got=err%b early%b exp=err1 early0", mem_err, err_pre);
            bad++;
        end
        ls_rd_req = 1'b0;
        cyc();
        stuck = 1'b0;
        wait_n = 1;
        if_addr = 8'd2;
        if_req = 1'b1;
        n = 0;
        do begin cyc(); n++; end while (!if_ack && n < 40);
        total++;
        if (n != 2 || if_data !== 16'h1234 || mem_err !== 1'b1) begin
            $display("FAIL err_sticky got=lat%0d data=%h err%b exp=lat2 data=1234 err1", n, if_data, mem_err);
            bad++;
        end
        if_req = 1'b0;
        cyc();
    endtask

    task automatic test_reset_mid_load();
        int n;
        wait_n = 5;
        ls_addr = 8'd130;
        ls_rd_req = 1'b1;
        cyc();
        cyc();
        total++;
        if (mem_rd !== 1'b1) begin
            $display("FAIL mid_pre_strobe got=%b exp=1", mem_rd);
            bad++;
        end
        ls_ack_n = 0;
        #1 rst = 1'b0;
        #1;
        total++;
        if ({mem_rd, mem_wr, ls_ack, if_ack, mem_err} !== 5'b0) begin
            $display("FAIL mid_reset_flags got=%b exp=00000", {mem_rd, mem_wr, ls_ack, if_ack, mem_err});
            bad++;
        end
        total++;
        if ({if_data, ls_rdata, mem_addr, mem_wdata} !== 56'h0) begin
            $display("FAIL mid_reset_data got=%h exp=0", {if_data, ls_rdata, mem_addr, mem_wdata});
            bad++;
        end
        ls_rd_req = 1'b0;
        cyc();
        cyc();
        rst = 1'b1;
        cyc();
        total++;
        if (ls_ack_n != 0) begin
            $display("FAIL mid_no_ack got=%0d exp=0", ls_ack_n);
            bad++;
        end
        ls_rd_req = 1'b1;
        n = 0;
        do begin cyc(); n++; end while (!ls_ack && n < 40);
        total++;
        if (n != 6 || ls_rdata !== 16'h0003) begin
            $display("FAIL mid_rerun got=lat%0d data=%h exp=lat6 data=0003", n, ls_rdata);
            bad++;
        end
        ls_rd_req = 1'b0;
        cyc();
        cyc();
    endtask

    initial begin
        for (int i = 0; i < 256; i++) tmem[i] = 16'(i);
        tmem[1] = 16'hE801;
        tmem[2] = 16'h1234;
        rst = 1'b0;
        if_req = 1'b0;
        if_addr = '0;
        ls_rd_req = 1'b0;
        ls_wr_req = 1'b0;
        ls_addr = '0;
        ls_wdata = '0;

        test_reset();
        test_zero_wait_fetch();
        test_store_load();
        test_contention();
        test_simul_rd_wr();
        test_timeout();
        test_reset_mid_load();

        total++;
        if (both_n != 0) begin
            $display("FAIL strobe_overlap got=%0d exp=0", both_n);
            bad++;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
